// File: rtl/hex_word_assembler_pkg.sv
// Shared types and constants for the hex word assembler.
// Optional build macro: HEX_UPPERCASE_EN (accept 'A'-'F' as hex digits).
package hex_word_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [7:0] ASC_0      = 8'h30;
  localparam logic [7:0] ASC_9      = 8'h39;
  localparam logic [7:0] ASC_LOW_A  = 8'h61;
  localparam logic [7:0] ASC_LOW_F  = 8'h66;
  localparam logic [7:0] ASC_UP_A   = 8'h41;
  localparam logic [7:0] ASC_UP_F   = 8'h46;
  localparam logic [7:0] ASC_SPACE  = 8'h20;
  localparam logic [7:0] ASC_LF     = 8'h0A;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;

endpackage

// File: rtl/hex_word_assembler_if.sv
// Character-in / word-out bus between the decode stage and word consumers.
interface hex_word_assembler_if #(
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned WORD_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

  logic [7:0]        char;
  logic              char_valid;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic [CNT_W-1:0]  digit_cnt;
  logic              err;

  modport master (
    output char, char_valid,
    input  word, word_valid, digit_cnt, err
  );

  modport slave (
    input  char, char_valid,
    output word, word_valid, digit_cnt, err
  );
endinterface

// File: rtl/hex_word_assembler_classify.sv
// Classifies one ASCII character as hex digit, delimiter or other.
// Optional build macro: HEX_UPPERCASE_EN (accept 'A'-'F' as hex digits).
module hex_char_classify
  import hex_word_assembler_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_hex_o,
  output logic       is_delim_o,
  output logic [3:0] nibble_o
);

  // Letters 'a'-'f' / 'A'-'F' sit at low nibble 1-6, so value = low nibble + 9.
  always_comb begin
    is_hex_o   = 1'b0;
    is_delim_o = 1'b0;
    nibble_o   = char_i[3:0];
    if (char_i >= ASC_0 && char_i <= ASC_9) begin
      is_hex_o = 1'b1;
    end else if (char_i >= ASC_LOW_A && char_i <= ASC_LOW_F) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
`ifdef HEX_UPPERCASE_EN
    end else if (char_i >= ASC_UP_A && char_i <= ASC_UP_F) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
`endif
    end else if (char_i == ASC_SPACE || char_i == ASC_LF ||
                 char_i == ASC_CR    || char_i == ASC_COMMA) begin
      is_delim_o = 1'b1;
    end
  end

endmodule

// File: rtl/hex_word_assembler.sv
// Packs delimiter-separated hex digit tokens into right-aligned words.
// Optional build macro: HEX_UPPERCASE_EN (accept 'A'-'F' as hex digits).
module hex_word_assembler
  import hex_word_assembler_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hex_word_assembler_if.slave  bus
);

  localparam int unsigned WORD_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] accum_q, accum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  digit_cnt_q, digit_cnt_d;
  logic              word_valid_q, word_valid_d;
  logic              err_q, err_d;

  logic              is_hex_c;
  logic              is_delim_c;
  logic [3:0]        nibble_c;

  hex_char_classify u_classify (
    .char_i     (bus.char),
    .is_hex_o   (is_hex_c),
    .is_delim_o (is_delim_c),
    .nibble_o   (nibble_c)
  );

  // State, accumulator and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      accum_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      digit_cnt_q  <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      accum_q      <= accum_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      digit_cnt_q  <= digit_cnt_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  // Token FSM: accumulate digits, publish on delimiter, park in ERR on bad input.
  always_comb begin
    state_d      = state_q;
    accum_d      = accum_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    digit_cnt_d  = digit_cnt_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;

    if (bus.char_valid) begin
      unique case (state_q)
        IDLE: begin
          if (is_hex_c) begin
            accum_d = WORD_W'(nibble_c);
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end else if (!is_delim_c) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        ACCUM: begin
          if (is_hex_c) begin
            if (cnt_q == CNT_W'(DIGITS)) begin
              accum_d = '0;
              cnt_d   = '0;
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              accum_d = {accum_q[WORD_W-5:0], nibble_c};
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else if (is_delim_c) begin
            word_d       = accum_q;
            digit_cnt_d  = cnt_q;
            word_valid_d = 1'b1;
            accum_d      = '0;
            cnt_d        = '0;
            state_d      = IDLE;
          end else begin
            accum_d = '0;
            cnt_d   = '0;
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        ERR: begin
          if (is_delim_c) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          accum_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.word       = word_q;
  assign bus.digit_cnt  = digit_cnt_q;
  assign bus.word_valid = word_valid_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_hex_word_assembler.sv
// Scoreboard bench for hex_word_assembler: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_hex_word_assembler;

  localparam int KIND_NONE = 0;
  localparam int KIND_WORD = 1;
  localparam int KIND_ERR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] w;
    logic [3:0]  c;
    longint      at;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  longint cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  exp_t   q[$];

  hex_word_assembler_if #(.DIGITS(8)) bus ();

  hex_word_assembler #(.DIGITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      while (q.size() > 0 && q[0].at < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: kind=%0d word=%h expected at cycle %0d, absent (now %0d)",
                 q[0].kind, q[0].w, q[0].at, cyc);
        void'(q.pop_front());
      end
      if (bus.word_valid || bus.err) begin
        int   got_kind;
        exp_t e;
        got_kind = bus.word_valid ? KIND_WORD : KIND_ERR;
        n_tests++;
        if (q.size() == 0 || q[0].at != cyc) begin
          n_fail++;
          $display("FAIL unexpected_event: got kind=%0d word=%h cnt=%0d at cycle %0d, required no event",
                   got_kind, bus.word, bus.digit_cnt, cyc);
        end else begin
          e = q.pop_front();
          if (got_kind != e.kind ||
              (e.kind == KIND_WORD && (bus.word != e.w || bus.digit_cnt != e.c))) begin
            n_fail++;
            $display("FAIL event_cycle_%0d: got kind=%0d word=%h cnt=%0d, required kind=%0d word=%h cnt=%0d",
                     cyc, got_kind, bus.word, bus.digit_cnt, e.kind, e.w, e.c);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Present one char for one cycle; called #1 after a rising edge.
  task automatic send_char(input byte c);
    bus.char       = c;
    bus.char_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
  endtask

  // Stream a token; the char at index pos produces the given event on the next cycle.
  task automatic send_tok(input string s, input int pos, input int kind,
                          input logic [31:0] w, input logic [3:0] c);
    for (int i = 0; i < s.len(); i++) begin
      if (i == pos && kind != KIND_NONE) begin
        exp_t e;
        e.kind = kind;
        e.w    = w;
        e.c    = c;
        e.at   = cyc + 1;
        q.push_back(e);
      end
      send_char(s[i]);
    end
  endtask

  task automatic idle(input int n);
    bus.char_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    bus.char       = 8'h00;
    bus.char_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_word", bus.word, 32'h0);
    check("reset_cnt", 32'(bus.digit_cnt), 32'h0);
    check("reset_valid", 32'(bus.word_valid), 32'h0);
    check("reset_err", 32'(bus.err), 32'h0);
    reset = 1'b1;
    idle(1);

    send_tok("1a2f ", 4, KIND_WORD, 32'h00001A2F, 4'd4);
    idle(3);
    check("hold_word", bus.word, 32'h00001A2F);
    check("hold_cnt", 32'(bus.digit_cnt), 32'd4);
    check("hold_valid_low", 32'(bus.word_valid), 32'h0);

    send_tok("deadbeef,", 8, KIND_WORD, 32'hDEADBEEF, 4'd8);
    send_tok("12\n", 2, KIND_WORD, 32'h00000012, 4'd2);

    send_tok("123456789 ", 8, KIND_ERR, 32'h0, 4'd0);
    send_tok("7 ", 1, KIND_WORD, 32'h00000007, 4'd1);

    send_tok("1g3 ", 1, KIND_ERR, 32'h0, 4'd0);
    send_tok("5 ", 1, KIND_WORD, 32'h00000005, 4'd1);

    send_tok("   ,\n", 0, KIND_NONE, 32'h0, 4'd0);

    send_tok("ab", 0, KIND_NONE, 32'h0, 4'd0);
    idle(5);
    send_tok(" ", 0, KIND_WORD, 32'h000000AB, 4'd2);

    send_tok("12", 0, KIND_NONE, 32'h0, 4'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midreset_word", bus.word, 32'h0);
    check("midreset_cnt", 32'(bus.digit_cnt), 32'h0);
    check("midreset_valid", 32'(bus.word_valid), 32'h0);
    check("midreset_err", 32'(bus.err), 32'h0);
    send_tok(" ", 0, KIND_NONE, 32'h0, 4'd0);
    idle(2);

`ifdef HEX_UPPERCASE_EN
    send_tok("F ", 1, KIND_WORD, 32'h0000000F, 4'd1);
`else
    send_tok("F ", 0, KIND_ERR, 32'h0, 4'd0);
`endif
    send_tok("c ", 1, KIND_WORD, 32'h0000000C, 4'd1);

    idle(4);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_word_assembler.md
Name: hex_word_assembler

Overview:
- Consumes an ASCII character stream, one char per valid cycle, and packs consecutive hex digits into one word.
- Emits a word on each delimiter.
- Sits directly downstream of the char-to-nibble decode stage and feeds word-level consumers, e.g. a register/memory loader.
- Flags malformed tokens: an invalid character, or too many digits.

Parameters:
- DIGITS, 8, maximum hex digits per word; word width = 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- char  input  8  ASCII character.
- char_valid  input  1  char is consumed on every rising edge where this is 1; no backpressure.
- word  output  4*DIGITS  last assembled word, right-aligned, zero-extended; held until the next word_valid.
- word_valid  output  1  one-cycle pulse; word and digit_cnt are valid.
- digit_cnt  output  $clog2(DIGITS+1)  number of digits in word.
- err  output  1  one-cycle pulse on entry to ERR.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE; accum=0; cnt=0.
  - word=0, word_valid=0, digit_cnt=0, err=0.
  - Reset mid-token discards the partial token; no word, no err.
- Char classes:
  - HEX: '0'-'9' gives nibble 0-9; 'a'-'f' gives nibble 10-15.
  - DELIM: 0x20 space, 0x0A LF, 0x0D CR, 0x2C ','.
  - OTHER: everything else, including 'A'-'F' unless the optional feature is enabled.
- Cycles with char_valid=0 change nothing. word_valid and err deassert after one cycle.
- IDLE:
  - HEX: accum=nibble, cnt=1, go to ACCUM.
  - DELIM: stay in IDLE; no output, so empty tokens are ignored.
  - OTHER: go to ERR, err=1 next cycle.
- ACCUM:
  - HEX with cnt<DIGITS: accum=(accum<<4)|nibble, cnt+=1.
  - HEX with cnt==DIGITS: overflow; go to ERR, err=1; accum discarded.
  - DELIM: word=accum, digit_cnt=cnt, word_valid=1 in the following cycle; clear accum/cnt; go to IDLE.
  - OTHER: go to ERR, err=1.
- ERR:
  - Discard HEX and OTHER, with no further err pulses.
  - DELIM: go to IDLE; no word.
- Latency: delimiter accepted at edge N → word_valid high during cycle N+1 (registered output).
- Back-to-back tokens are allowed with a single delimiter between them. Sustained throughput is one char per cycle.
- accum shift is exactly 4*DIGITS bits wide; no bits are lost below the DIGITS limit.

Optional Feature:
- Macro HEX_UPPERCASE_EN.
- Defined: 'A'-'F' are classed HEX with nibbles 10-15.
- Undefined: 'A'-'F' are OTHER and trigger ERR.

Decomposition:
- Shared package: state encodings IDLE/ACCUM/ERR; ASCII constants for '0', '9', 'a', 'f', 'A', 'F', space, LF, CR, comma.
- One combinational sub-module, hex_char_classify: input char; outputs is_hex, is_delim, nibble[3:0].
- The FSM, accumulator and output registers live in hex_word_assembler.

Test Plan:
- "1a2f " streamed, valid every cycle → one cycle after the space: word=0x00001A2F, digit_cnt=4, word_valid for exactly 1 cycle, err=0.
- "deadbeef,12\n" → word=0xDEADBEEF, cnt=8; then word=0x00000012, cnt=2; two pulses, one cycle after each delimiter.
- "123456789 " (9 digits, DIGITS=8) → err pulse on the cycle after the 9th digit; no word_valid; next token "7 " → word=0x7, cnt=1.
- "1g3 5 " → err after 'g'; '3' ignored with no second err; after the space, "5 " → word=0x5.
- Gaps and reset:
  - "   ,\n" → no word_valid, no err.
  - "ab", then char_valid low for 5 cycles, then " " → word=0xAB.
  - "12" then reset low for 1 cycle, then " " → no word; outputs at reset values.
- 'F' then ' ': with HEX_UPPERCASE_EN, word=0xF; without it, err pulse and no word.
